// File: rtl/alu_muldiv_sequencer_if.sv
// rtl/alu_muldiv_sequencer_if.sv - start/operand, shared-ALU and result signals of the mul/div sequencer
interface alu_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] alu_operandA;
    logic [WIDTH-1:0] alu_operandB;
    logic [4:0]       alu_opcode;
    logic [4:0]       alu_shiftamt;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
        output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
               data_result, data_exception, data_resultRDY, busy
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
        input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
               data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// rtl/alu_muldiv_sequencer.sv - signed 32-bit multi-cycle multiply/divide driving the shared ALU
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    alu_muldiv_sequencer_if.slave bus
);
    localparam int               CW      = $clog2(ITERS);
    localparam logic [CW-1:0]    LAST    = CW'(ITERS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0]       OP_ADD  = 5'd0;
    localparam logic [4:0]       OP_SUB  = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_FIX, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic             r_is_div;
    logic             r_sign;
    logic [WIDTH-1:0] r_hi;      // HI (multiply) / partial remainder R (divide)
    logic [WIDTH-1:0] r_lo;      // LO (multiply) / quotient Q (divide); |A| before ITER
    logic [WIDTH-1:0] r_m;       // multiplicand M / divisor D; |B| after ABS_B
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    logic [WIDTH-1:0] w_alu_a, w_alu_b;
    logic [4:0]       w_alu_op;
    logic [WIDTH-1:0] w_rp;
    logic             w_carry, w_borrow, w_ge;
    logic [WIDTH-1:0] w_fix_res;
    logic             w_fix_exc;
    logic             w_start;
    logic             w_div_zero;

    assign w_start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_div_zero = ~bus.ctrl_MULT & bus.ctrl_DIV & (bus.data_operandB == '0);

    // Carry/borrow recovered from operand and result sign bits since the ALU has no carry-out
    assign w_rp     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_carry  = (w_alu_a[WIDTH-1] & w_alu_b[WIDTH-1]) |
                      ((w_alu_a[WIDTH-1] | w_alu_b[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
    assign w_borrow = (~w_rp[WIDTH-1] & r_m[WIDTH-1]) |
                      (~(w_rp[WIDTH-1] ^ r_m[WIDTH-1]) & bus.alu_result[WIDTH-1]);
    assign w_ge     = r_hi[WIDTH-1] | ~w_borrow;

    assign w_fix_res = r_sign ? bus.alu_result : r_lo;
    assign w_fix_exc = r_is_div ? (~r_sign & r_lo[WIDTH-1])
                                : ((r_hi != '0) || (r_lo[WIDTH-1] && !(r_sign && (r_lo == MIN_NEG))));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = OP_ADD;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_div_zero ? S_DONE : S_ABS_A;
                end
            end
            S_ABS_A: begin
                w_alu_b  = r_lo;
                w_alu_op = OP_SUB;
                w_next   = S_ABS_B;
            end
            S_ABS_B: begin
                w_alu_b  = r_m;
                w_alu_op = OP_SUB;
                w_next   = S_ITER;
            end
            S_ITER: begin
                if (r_is_div) begin
                    w_alu_a  = w_rp;
                    w_alu_b  = r_m;
                    w_alu_op = OP_SUB;
                end else begin
                    w_alu_a  = r_hi;
                    w_alu_b  = r_lo[0] ? r_m : '0;
                    w_alu_op = OP_ADD;
                end
                if (r_cnt == LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_alu_b  = r_lo;
                w_alu_op = OP_SUB;
                w_next   = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_sign   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_div <= ~bus.ctrl_MULT;
                        r_lo     <= bus.data_operandA;
                        r_m      <= bus.data_operandB;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        r_sign   <= 1'b0;
                        if (w_div_zero) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                        end
                    end
                end
                S_ABS_A: begin
                    r_sign <= r_lo[WIDTH-1];
                    r_lo   <= r_lo[WIDTH-1] ? bus.alu_result : r_lo;
                end
                S_ABS_B: begin
                    r_sign <= r_sign ^ r_m[WIDTH-1];
                    r_m    <= r_m[WIDTH-1] ? bus.alu_result : r_m;
                    r_hi   <= '0;
                    r_cnt  <= '0;
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_ge ? bus.alu_result : w_rp;
                        r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    end else begin
                        r_hi <= {w_carry, bus.alu_result[WIDTH-1:1]};
                        r_lo <= {bus.alu_result[0], r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_exc    <= w_fix_exc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_operandA   = w_alu_a;
    assign bus.alu_operandB   = w_alu_b;
    assign bus.alu_opcode     = w_alu_op;
    assign bus.alu_shiftamt   = 5'd0;
    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = (r_state == S_DONE);
    assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb/tb_alu_muldiv_sequencer.sv - self-checking bench for alu_muldiv_sequencer with an ALU model
module tb_alu_muldiv_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_muldiv_sequencer_if bus ();

    alu_muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.alu_result = (bus.alu_opcode == 5'd0) ? bus.alu_operandA + bus.alu_operandB
                                                     : bus.alu_operandA - bus.alu_operandB;

    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = (p > 64'sd2147483647);
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: begin
                v = $urandom_range(0, 400);
                v = v - 32'd200;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic exc,
                          output int busy_low, output int bad_alu,
                          output logic post_busy, output logic post_rdy);
        @(negedge clock);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        lat = -1;
        res = 32'd0;
        exc = 1'b0;
        busy_low = 0;
        bad_alu = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (!bus.busy) busy_low++;
            if (bus.alu_opcode > 5'd1 || bus.alu_shiftamt != 5'd0) bad_alu++;
            if (bus.data_resultRDY) begin
                lat = c;
                res = bus.data_result;
                exc = bus.data_exception;
                break;
            end
        end
        @(negedge clock);
        post_busy = bus.busy;
        post_rdy = bus.data_resultRDY;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: result=%h exc=%b rdy=%b busy=%b, required all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        checks++;
        if ({bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt} !== 74'd0) begin
            errors++;
            $display("FAIL reset_alu_drive: a=%h b=%h op=%0d sh=%0d, required all 0",
                     bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt);
        end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        bit          t_div [7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [31:0] t_a   [7] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FF9C,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        logic [31:0] t_b   [7] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'd7,
                                   32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] t_r   [7] = '{32'hFFFF_FFD6, 32'd0, 32'h8000_0000, 32'hFFFF_FFF2,
                                   32'd0, 32'd0, 32'h8000_0000};
        logic        t_e   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int          t_lat [7] = '{36, 36, 36, 36, 36, 1, 36};
        int lat, bl, ba;
        logic [31:0] res;
        logic exc, pb, pr;
        for (int i = 0; i < 7; i++) begin
            run_op(!t_div[i], t_div[i], t_a[i], t_b[i], lat, res, exc, bl, ba, pb, pr);
            checks++;
            if (lat !== t_lat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, t_lat[i]);
            end
            checks++;
            if (res !== t_r[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, t_r[i]);
            end
            checks++;
            if (exc !== t_e[i]) begin
                errors++;
                $display("FAIL directed_exception[%0d]: got %b, required %b", i, exc, t_e[i]);
            end
            checks++;
            if (bl !== 0 || ba !== 0) begin
                errors++;
                $display("FAIL directed_busy_alu[%0d]: busy-low cycles %0d, bad ALU cycles %0d, required 0 and 0",
                         i, bl, ba);
            end
            checks++;
            if (pb !== 1'b0 || pr !== 1'b0) begin
                errors++;
                $display("FAIL directed_after_strobe[%0d]: busy=%b rdy=%b, required 0 0", i, pb, pr);
            end
        end
    endtask

    task automatic test_random();
        int lat, bl, ba, exp_lat;
        logic [31:0] a, b, res, exp_r;
        logic exc, exp_e, pb, pr;
        bit is_div;
        for (int i = 0; i < 24; i++) begin
            is_div = ($urandom_range(0, 1) == 1);
            a = pick();
            b = pick();
            model(is_div, a, b, exp_r, exp_e);
            exp_lat = (is_div && b == 32'd0) ? 1 : 36;
            run_op(!is_div, is_div, a, b, lat, res, exc, bl, ba, pb, pr);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
            end
            checks++;
            if (res !== exp_r || exc !== exp_e) begin
                errors++;
                $display("FAIL random_result[%0d] div=%0d a=%h b=%h: got %h/%b, required %h/%b",
                         i, is_div, a, b, res, exc, exp_r, exp_e);
            end
        end
    endtask

    task automatic test_both_start();
        int lat, bl, ba;
        logic [31:0] res;
        logic exc, pb, pr;
        run_op(1'b1, 1'b1, 32'd6, 32'd3, lat, res, exc, bl, ba, pb, pr);
        checks++;
        if (res !== 32'd18 || exc !== 1'b0 || lat !== 36) begin
            errors++;
            $display("FAIL both_start: got %h/%b lat %0d, required 00000012/0 lat 36", res, exc, lat);
        end
    endtask

    task automatic test_ignore_midrun();
        int strobes, lat;
        logic [31:0] res, exp_r;
        logic exp_e;
        model(1'b0, 32'd123, 32'hFFFF_FFD3, exp_r, exp_e);
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd123;
        bus.data_operandB = 32'hFFFF_FFD3;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        strobes = 0;
        lat = -1;
        res = 32'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 10) begin
                bus.ctrl_DIV = 1'b1;
                bus.data_operandB = 32'd0;
            end
            if (c == 11) bus.ctrl_DIV = 1'b0;
            if (bus.data_resultRDY) begin
                strobes++;
                if (lat < 0) begin
                    lat = c;
                    res = bus.data_result;
                end
            end
        end
        checks++;
        if (strobes !== 1 || lat !== 36) begin
            errors++;
            $display("FAIL ignore_midrun_strobes: got %0d strobes first at %0d, required 1 at 36", strobes, lat);
        end
        checks++;
        if (res !== exp_r) begin
            errors++;
            $display("FAIL ignore_midrun_result: got %h, required %h", res, exp_r);
        end
    endtask

    task automatic test_reset_midrun();
        int strobes, lat, bl, ba;
        logic [31:0] res;
        logic exc, pb, pr;
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd1000;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        for (int c = 1; c <= 13; c++) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy,
             bus.alu_operandA, bus.alu_operandB, bus.alu_opcode} !== 104'd0) begin
            errors++;
            $display("FAIL reset_midrun_outputs: result=%h exc=%b rdy=%b busy=%b a=%h b=%h op=%0d, required all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy,
                     bus.alu_operandA, bus.alu_operandB, bus.alu_opcode);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY || bus.busy) strobes++;
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL reset_midrun_no_strobe: got %0d busy/strobe cycles, required 0", strobes);
        end
        run_op(1'b1, 1'b0, 32'd3, 32'd3, lat, res, exc, bl, ba, pb, pr);
        checks++;
        if (res !== 32'd9 || exc !== 1'b0 || lat !== 36) begin
            errors++;
            $display("FAIL reset_midrun_restart: got %h/%b lat %0d, required 00000009/0 lat 36", res, exc, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] exp_r;
        logic exp_e, idle_busy;
        model(1'b0, 32'hFFFF_FFF7, 32'd11, exp_r, exp_e);
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd12;
        bus.data_operandB = 32'd12;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        lat1 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                lat1 = c;
                break;
            end
        end
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'hFFFF_FFF7;
        bus.data_operandB = 32'd11;
        @(posedge clock);
        @(negedge clock);
        idle_busy = bus.busy;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                lat2 = c;
                break;
            end
        end
        checks++;
        if (lat1 !== 36 || idle_busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_first: lat %0d busy-after-done %b, required 36 and 0", lat1, idle_busy);
        end
        checks++;
        if (lat2 !== 36 || bus.data_result !== exp_r || bus.data_exception !== exp_e) begin
            errors++;
            $display("FAIL back_to_back_second: lat %0d got %h/%b, required 36 %h/%b",
                     lat2, bus.data_result, bus.data_exception, exp_r, exp_e);
        end
        @(negedge clock);
    endtask

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_both_start();
        test_ignore_midrun();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
